stopwatch_core: RTL and testbench

Stopwatch timebase consumer that sits directly downstream of the 100 Hz prescaler. Samples the prescaler's 100 Hz square wave in the sysclk domain, turns each rising edge into a one-cycle count enable, and keeps an MM:SS.cc BCD count from 00:00.00 to 59:59.99. Start/stop and lap/clear controls come from debounced one-cycle button pulses. BCD digit outputs feed the 7-segment scan driver.

---
 rtl/stopwatch_core.sv | 147 ++++++++++++++
 tb/tb_stopwatch_core.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// MM:SS.cc BCD stopwatch counting rising edges of the 100 Hz prescaler output,
// with run/stop, lap freeze and clear driven by one-cycle button pulses.
module stopwatch_core (
  input  logic       sysclk,
  input  logic       i_rst_n,
  input  logic       i_100hz_clk,
  input  logic       i_start_stop,
  input  logic       i_lap_clr,
  output logic [3:0] o_cs_ones,
  output logic [3:0] o_cs_tens,
  output logic [3:0] o_s_ones,
  output logic [3:0] o_s_tens,
  output logic [3:0] o_m_ones,
  output logic [3:0] o_m_tens,
  output logic       o_running,
  output logic       o_lap,
  output logic       o_tick
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP,
    S_LAP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_prev;
  logic        r_tick;
  logic        w_tick;
  logic        w_count;
  logic        w_latch;
  logic        w_clear;
  logic [23:0] r_live;
  logic [23:0] r_lap;
  logic [23:0] w_live_inc;
  logic [23:0] w_disp;
  logic [5:0]  w_en;

  // Digit packing, LSB first: cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens.
  function automatic logic [3:0] bcd_next(input logic [3:0] d,
                                          input logic [3:0] lim,
                                          input logic       en);
    if (!en)
      return d;
    else if (d == lim)
      return 4'd0;
    else
      return d + 4'd1;
  endfunction

  assign w_tick = i_100hz_clk & ~r_prev;

  // Each digit steps only when every lower digit sits at its wrap value.
  assign w_en[0] = 1'b1;
  assign w_en[1] = w_en[0] & (r_live[3:0]   == 4'd9);
  assign w_en[2] = w_en[1] & (r_live[7:4]   == 4'd9);
  assign w_en[3] = w_en[2] & (r_live[11:8]  == 4'd9);
  assign w_en[4] = w_en[3] & (r_live[15:12] == 4'd5);
  assign w_en[5] = w_en[4] & (r_live[19:16] == 4'd9);

  assign w_live_inc = {bcd_next(r_live[23:20], 4'd5, w_en[5]),
                       bcd_next(r_live[19:16], 4'd9, w_en[4]),
                       bcd_next(r_live[15:12], 4'd5, w_en[3]),
                       bcd_next(r_live[11:8],  4'd9, w_en[2]),
                       bcd_next(r_live[7:4],   4'd9, w_en[1]),
                       bcd_next(r_live[3:0],   4'd9, w_en[0])};

  assign w_count = w_tick & ((r_state == S_RUN) | (r_state == S_LAP));

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start_stop)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_start_stop) begin
          w_state_nxt = S_STOP;
        end else if (i_lap_clr) begin
          w_state_nxt = S_LAP;
          w_latch     = 1'b1;
        end
      end
      S_LAP: begin
        if (i_start_stop)
          w_state_nxt = S_STOP;
        else if (i_lap_clr)
          w_state_nxt = S_RUN;
      end
      S_STOP: begin
        if (i_start_stop) begin
          w_state_nxt = S_RUN;
        end else if (i_lap_clr) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_prev  <= 1'b1;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= i_100hz_clk;
      r_tick  <= w_tick;
    end
  end

  // Latch takes the pre-increment value when a tick lands on lap entry.
  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_live <= '0;
      r_lap  <= '0;
    end else if (w_clear) begin
      r_live <= '0;
      r_lap  <= '0;
    end else begin
      if (w_count)
        r_live <= w_live_inc;
      if (w_latch)
        r_lap <= r_live;
    end
  end

  assign w_disp = (r_state == S_LAP) ? r_lap : r_live;

  assign o_cs_ones = w_disp[3:0];
  assign o_cs_tens = w_disp[7:4];
  assign o_s_ones  = w_disp[11:8];
  assign o_s_tens  = w_disp[15:12];
  assign o_m_ones  = w_disp[19:16];
  assign o_m_tens  = w_disp[23:20];
  assign o_running = (r_state == S_RUN) | (r_state == S_LAP);
  assign o_lap     = (r_state == S_LAP);
  assign o_tick    = r_tick;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: fixed vector table, directed corner sequences and
// random pulses checked against a centisecond-count reference model.
module tb_stopwatch_core;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       hz;
  logic       ss;
  logic       lc;
  logic [3:0] o_cs_ones, o_cs_tens, o_s_ones, o_s_tens, o_m_ones, o_m_tens;
  logic       o_running, o_lap, o_tick;
  logic [23:0] disp;

  always #5 sysclk = ~sysclk;

  stopwatch_core dut (
    .sysclk      (sysclk),
    .i_rst_n     (rst_n),
    .i_100hz_clk (hz),
    .i_start_stop(ss),
    .i_lap_clr   (lc),
    .o_cs_ones   (o_cs_ones),
    .o_cs_tens   (o_cs_tens),
    .o_s_ones    (o_s_ones),
    .o_s_tens    (o_s_tens),
    .o_m_ones    (o_m_ones),
    .o_m_tens    (o_m_tens),
    .o_running   (o_running),
    .o_lap       (o_lap),
    .o_tick      (o_tick)
  );

  assign disp = {o_m_tens, o_m_ones, o_s_tens, o_s_ones, o_cs_tens, o_cs_ones};

  int n_checks = 0;
  int n_fail   = 0;
  int tick_seen = 0;

  // Reference model: elapsed time as a plain centisecond count.
  int unsigned m_count, m_frozen;
  bit m_run, m_lap, m_prev, m_tick;

  function automatic logic [23:0] to_bcd(input int unsigned v);
    int unsigned mm, sec, cc;
    mm  = v / 6000;
    sec = (v / 100) % 60;
    cc  = v % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(sec / 10), 4'(sec % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic logic [23:0] model_disp();
    return m_lap ? to_bcd(m_frozen) : to_bcd(m_count);
  endfunction

  task automatic model_reset();
    m_count = 0; m_frozen = 0; m_run = 0; m_lap = 0; m_prev = 1; m_tick = 0;
  endtask

  task automatic model_edge(input logic h, input logic s, input logic l);
    int unsigned old;
    old    = m_count;
    m_tick = h & ~m_prev;
    m_prev = h;
    if (m_tick && m_run) m_count = (m_count + 1) % 360000;
    if (s) begin
      if (m_run) begin m_run = 0; m_lap = 0; end
      else m_run = 1;
    end else if (l) begin
      if (m_run) begin
        if (!m_lap) begin m_lap = 1; m_frozen = old; end
        else m_lap = 0;
      end else begin
        m_count = 0; m_frozen = 0;
      end
    end
  endtask

  task automatic check_val(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic h, input logic s, input logic l, input bit chk);
    hz = h; ss = s; lc = l;
    @(posedge sysclk);
    model_edge(h, s, l);
    #1;
    if (o_tick) tick_seen++;
    if (chk) begin
      check_val("display", disp, model_disp());
      check_val("running", 24'(o_running), 24'(m_run));
      check_val("lap",     24'(o_lap),     24'(m_lap));
      check_val("tick",    24'(o_tick),    24'(m_tick));
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic pulse(input logic s, input logic l);
    step(1'b0, s, l, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hz = 1'b0; ss = 1'b0; lc = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        hz;
    logic        ss;
    logic        lc;
    logic [23:0] disp;
    logic        run;
    logic        lap;
    logic        tick;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 24'h000001, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 24'h000001, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 24'h000001, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 24'h000002, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 24'h000003, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 24'h000003, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 24'h000003, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 24'h000001, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 24'h000001, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 24'h000001, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 24'h000001, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 24'h000001, 1'b1, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 24'h000002, 1'b0, 1'b0, 1'b0};

    model_reset();
    do_reset();
    check_val("reset disp", disp, 24'h000000);
    check_val("reset running", 24'(o_running), 24'h0);
    check_val("reset lap", 24'(o_lap), 24'h0);
    check_val("reset tick", 24'(o_tick), 24'h0);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].hz, tbl[i].ss, tbl[i].lc, 1'b0);
      check_val($sformatf("vec%0d disp", i), disp, tbl[i].disp);
      check_val($sformatf("vec%0d running", i), 24'(o_running), 24'(tbl[i].run));
      check_val($sformatf("vec%0d lap", i), 24'(o_lap), 24'(tbl[i].lap));
      check_val($sformatf("vec%0d tick", i), 24'(o_tick), 24'(tbl[i].tick));
    end

    // Idle ticks still pulse o_tick but never count.
    do_reset();
    tick_seen = 0;
    tick_n(100);
    check_val("idle tick count", 24'(tick_seen), 24'd100);
    check_val("idle disp", disp, 24'h000000);
    check_val("idle running", 24'(o_running), 24'h0);

    pulse(1'b1, 1'b0);
    tick_n(123);
    check_val("run 123", disp, 24'h000123);
    pulse(1'b1, 1'b0);
    tick_n(10);
    check_val("stopped hold", disp, 24'h000123);
    pulse(1'b1, 1'b0);
    tick_n(1);
    check_val("resume", disp, 24'h000124);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    check_val("clear", disp, 24'h000000);

    pulse(1'b1, 1'b0);
    tick_n(50);
    pulse(1'b0, 1'b1);
    check_val("lap freeze", disp, 24'h000050);
    check_val("lap flag", 24'(o_lap), 24'h1);
    tick_n(30);
    check_val("lap frozen", disp, 24'h000050);
    pulse(1'b0, 1'b1);
    check_val("lap release", disp, 24'h000080);
    check_val("lap flag off", 24'(o_lap), 24'h0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);

    pulse(1'b1, 1'b0);
    tick_n(6000);
    check_val("one minute", disp, 24'h010000);
    pulse(1'b1, 1'b0);

    // Preload the live count near the top while stopped to reach the rollover.
    force dut.r_live = 24'h595998;
    #1;
    release dut.r_live;
    m_count = 359998;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("max count", disp, 24'h595999);
    tick_n(1);
    check_val("rollover", disp, 24'h000000);
    check_val("rollover running", 24'(o_running), 24'h1);

    // Asynchronous reset in LAP, released while the 100 Hz input is high.
    do_reset();
    pulse(1'b1, 1'b0);
    tick_n(1234);
    pulse(1'b0, 1'b1);
    check_val("pre-reset lap", disp, 24'h001234);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    check_val("async rst disp", disp, 24'h000000);
    check_val("async rst running", 24'(o_running), 24'h0);
    check_val("async rst lap", 24'(o_lap), 24'h0);
    check_val("async rst tick", 24'(o_tick), 24'h0);
    @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("no tick after rst", 24'(o_tick), 24'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("first real edge", 24'(o_tick), 24'h1);

    // Random input activity against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 29) == 0), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
